// File: rtl/scope_capture_if.sv
// Audio-in / video-timing / waveform-out signal bundle for the oscilloscope capture block.
// The master drives samples and video timing; the slave returns the waveform column.
interface scope_capture_if;
    logic signed [15:0] audio_sample;
    logic               sample_strobe;
    logic               frame_start;
    logic               line_start;
    logic [8:0]         line_index;
    logic [6:0]         scope_x;
    logic               scope_valid;

    modport master (
        output audio_sample, sample_strobe, frame_start, line_start, line_index,
        input  scope_x, scope_valid
    );

    modport slave (
        input  audio_sample, sample_strobe, frame_start, line_start, line_index,
        output scope_x, scope_valid
    );
endinterface

// File: rtl/scope_capture.sv
// Triggered audio oscilloscope: captures 128 decimated samples into one bank while the
// other bank is read out one column per scanline; banks swap at a frame boundary once full.
module scope_capture #(
    parameter int DECIM        = 4,
    parameter int TRIG_TIMEOUT = 1024
) (
    input  logic            clk48,
    input  logic            rst_n,
    scope_capture_if.slave  bus
);
    localparam int TMO_W = $clog2(TRIG_TIMEOUT + 1);
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TRIG_TIMEOUT - 1);
    localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
    localparam logic [6:0]       MID_X    = 7'd64;

    typedef enum logic [1:0] {ST_ARM, ST_CAPTURE, ST_DONE} state_e;

    state_e           state_q;
    logic             bank_sel_q;
    logic             valid_q;
    logic             prev_sign_q;
    logic [6:0]       scope_x_q;
    logic [6:0]       waddr_q;
    logic [TMO_W-1:0] tmo_q;
    logic [DEC_W-1:0] dec_q;

    // Both banks live in one array: the MSB of the index is the bank number.
    logic [6:0] mem [256];

    logic [6:0] sample_code;
    logic       trig;
    logic       dec_wrap;
    logic       mem_we;
    logic [6:0] mem_addr;

    assign sample_code = {~bus.audio_sample[15], bus.audio_sample[14:9]};

    always_comb begin
        trig     = 1'b0;
        dec_wrap = 1'b0;
        mem_we   = 1'b0;
        mem_addr = waddr_q;
        if (bus.sample_strobe) begin
            case (state_q)
                ST_ARM: begin
                    trig     = (prev_sign_q && !bus.audio_sample[15]) || (tmo_q == TMO_LAST);
                    mem_we   = trig;
                    mem_addr = 7'd0;
                end
                ST_CAPTURE: begin
                    dec_wrap = (dec_q == DEC_LAST);
                    mem_we   = dec_wrap;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sample memory has no reset; its contents are masked by valid_q until a full capture is swapped in.
    always_ff @(posedge clk48) begin
        if (mem_we) mem[{~bank_sel_q, mem_addr}] <= sample_code;
    end

    // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARM;
            bank_sel_q  <= 1'b0;
            valid_q     <= 1'b0;
            prev_sign_q <= 1'b0;
            scope_x_q   <= MID_X;
            waddr_q     <= '0;
            tmo_q       <= '0;
            dec_q       <= '0;
        end else begin
            if (bus.line_start) begin
                scope_x_q <= valid_q ? mem[{bank_sel_q, bus.line_index[8:2]}] : MID_X;
            end

            case (state_q)
                ST_ARM: begin
                    if (bus.sample_strobe) begin
                        prev_sign_q <= bus.audio_sample[15];
                        tmo_q       <= tmo_q + 1'b1;
                        if (trig) begin
                            waddr_q <= 7'd1;
                            dec_q   <= '0;
                            state_q <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (bus.sample_strobe) begin
                        if (dec_wrap) begin
                            dec_q   <= '0;
                            waddr_q <= waddr_q + 1'b1;
                            if (waddr_q == 7'd127) state_q <= ST_DONE;
                        end else begin
                            dec_q <= dec_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // A strobe coinciding with the swap is deliberately dropped.
                    if (bus.frame_start) begin
                        bank_sel_q <= ~bank_sel_q;
                        valid_q    <= 1'b1;
                        tmo_q      <= '0;
                        dec_q      <= '0;
                        state_q    <= ST_ARM;
                    end
                end
                default: state_q <= ST_ARM;
            endcase
        end
    end

    assign bus.scope_x     = scope_x_q;
    assign bus.scope_valid = valid_q;
endmodule
